bp_table_sched: RTL
===================

Name: bp_table_sched

Overview:
- Scheduler for the branch-prediction pattern table, which is a single-port SRAM shared between two requesters:
  - IF-stage lookups.
  - EX-stage counter updates.
- Buffers resolved-branch updates in a small FIFO and performs the 2-bit counter read-modify-write (RMW).
- Owns the global history register (GHR) and forms the table index.
- Lookups have priority over updates; a starvation guard and a full FIFO force updates through.

Parameters:
- IDX_W, 5, number of PC bits used in the index (pc[IDX_W+1:2]).
- GHR_W, 2, global history length.
- FIFO_DEPTH, 4, update FIFO entries; must be a power of 2.
- STARVE_LIMIT, 8, cycles a non-empty FIFO may wait before an update is forced.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (rst==0 resets).
- if_req  in  1  lookup request.
- if_pc  in  32  PC of the lookup.
- if_ready  out  1  lookup accepted this cycle (combinational).
- pred_valid  out  1  prediction valid, one cycle after acceptance.
- pred_taken  out  1  predicted direction.
- ex_valid  in  1  resolved-branch update valid.
- ex_pc  in  32  PC of the resolved branch.
- ex_taken  in  1  actual branch outcome.
- ex_ready  out  1  update accepted (= FIFO not full).
- tbl_en  out  1  table port enable.
- tbl_we  out  1  table write enable.
- tbl_addr  out  GHR_W+IDX_W  table address.
- tbl_wdata  out  2  counter write data.
- tbl_rdata  in  2  counter read data; valid the cycle after a read.
- ghr_out  out  GHR_W  current GHR.

Behaviour:
- Index for a PC p: {ghr, p[IDX_W+1:2]}.
  - Lookups use the GHR value current at acceptance.
  - Updates use the GHR value current at enqueue, captured into the FIFO entry together with ex_taken.
- GHR: on each accepted update, ghr <= {ghr[GHR_W-2:0], ex_taken}.
- FSM states:
  - IDLE: the port is free for a lookup or an update read.
  - UPD_WR: the port is reserved for the RMW write.
- Update grant (evaluated in IDLE): FIFO non-empty AND (!if_req OR FIFO full OR starve_cnt >= STARVE_LIMIT).
  - On grant: issue a read of the head entry's index (tbl_en=1, tbl_we=0), then go to UPD_WR.
- UPD_WR:
  - Issue the write: tbl_en=1, tbl_we=1, tbl_addr = head index.
  - tbl_wdata = saturating counter: taken -> min(3, rdata+1); not taken -> max(0, rdata-1).
  - Pop the FIFO and return to IDLE.
- Lookup:
  - if_ready = (state==IDLE) && !update_grant.
  - If if_req && if_ready in cycle t: read issued in cycle t.
  - Cycle t+1: pred_valid=1, pred_taken=tbl_rdata[1]. pred_valid is otherwise 0.
  - Back-to-back lookups give one prediction per cycle.
- tbl_* outputs are combinational from state/requests; all zero when the port is unused.
- The table is write-first: a read in the cycle after a write returns the new value.
- Update enqueue:
  - ex_ready = !full.
  - Enqueue and dequeue in the same cycle are legal when not full; occupancy is unchanged.
  - ex_valid while full is ignored; the GHR does not shift.
- starve_cnt:
  - Increments (saturating) each cycle the FIFO is non-empty and no update is granted.
  - Clears on update grant.
- Reset values:
  - FSM = IDLE, FIFO empty, ghr=0, starve_cnt=0.
  - pred_valid=0, pred_taken=0, ex_ready=1, if_ready=0.
  - All tbl_* = 0.
- Reset asserted mid-RMW: the pending write is abandoned, no table write occurs, and the FIFO is cleared.
- No table initialisation is done here; table contents are the integrator's concern.

Test Plan:
- After reset, 3 consecutive lookups at pc 0x10, 0x14, 0x18 with an empty FIFO, table preloaded with 2,1,3 -> tbl_addr 4,5,6; pred_taken 1,0,1 on cycles t+1..t+3; pred_valid high for exactly 3 cycles.
- Update ex_pc=0x20, taken, with ghr=0 and counter=1, if_req low -> read of addr 8 in cycle 1, write 2 to addr 8 in cycle 2; ghr_out=1 after enqueue; a counter at 3 stays 3; not-taken on 0 stays 0.
- if_req held high with 1 update queued -> if_ready high for 8 cycles, then update forced: if_ready low for 2 cycles (read, write), starve_cnt back to 0.
- 4 updates enqueued while lookups stream -> ex_ready drops; next IDLE cycle grants an update; a 5th ex_valid while full is dropped and ghr is unchanged.
- Update write to addr 8 in cycle t, lookup of the same index in t+1 -> pred_taken reflects the new counter (2 -> predicted taken).
- rst driven low during UPD_WR -> tbl_we stays 0, FIFO empty, ghr=0, ex_ready=1 after release.

Source files
------------

// File: rtl/bp_table_sched.sv
// Scheduler for the single-port branch-prediction pattern table.
// IF lookups normally own the port; resolved-branch updates are queued and
// applied as a read-modify-write of the 2-bit counter when the port is free,
// when the queue is full, or when the queue head has waited too long.
module bp_table_sched #(
  parameter int unsigned IDX_W        = 5,
  parameter int unsigned GHR_W        = 2,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req,
  input  logic [31:0]            if_pc,
  output logic                   if_ready,
  output logic                   pred_valid,
  output logic                   pred_taken,
  input  logic                   ex_valid,
  input  logic [31:0]            ex_pc,
  input  logic                   ex_taken,
  output logic                   ex_ready,
  output logic                   tbl_en,
  output logic                   tbl_we,
  output logic [GHR_W+IDX_W-1:0] tbl_addr,
  output logic [1:0]             tbl_wdata,
  input  logic [1:0]             tbl_rdata,
  output logic [GHR_W-1:0]       ghr_out
);

  localparam int unsigned AW    = GHR_W + IDX_W;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [PTR_W:0]   FifoFull  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] StarveMax = CNT_W'(STARVE_LIMIT);

  typedef enum logic [0:0] {StIdle, StUpdWr} state_e;

  state_e state_q, state_d;

  // Update queue: table index (with GHR captured at enqueue) and outcome
  logic [AW-1:0]    fifo_idx_q [FIFO_DEPTH];
  logic             fifo_tkn_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             pred_valid_q;

  logic          empty, full, push, pop;
  logic          upd_grant, lookup;
  logic [AW-1:0] head_idx;
  logic          head_taken;
  logic [AW-1:0] lookup_idx;
  logic [1:0]    upd_cnt;

  // PC bits outside the index field are intentionally ignored
  logic unused_pc;
  assign unused_pc = ^{if_pc[31:IDX_W+2], if_pc[1:0], ex_pc[31:IDX_W+2], ex_pc[1:0]};

  assign empty      = (count_q == '0);
  assign full       = (count_q == FifoFull);
  assign head_idx   = fifo_idx_q[rd_ptr_q];
  assign head_taken = fifo_tkn_q[rd_ptr_q];
  assign lookup_idx = {ghr_q, if_pc[IDX_W+1:2]};

  assign ex_ready = !full;
  assign push     = ex_valid && !full;
  assign pop      = (state_q == StUpdWr);

  assign upd_grant = (state_q == StIdle) && !empty &&
                     (!if_req || full || (starve_q >= StarveMax));
  // Gated by rst so no lookup is accepted (and the port stays idle) during reset
  assign if_ready  = rst && (state_q == StIdle) && !upd_grant;
  assign lookup    = if_req && if_ready;

  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_valid_q & tbl_rdata[1];
  assign ghr_out    = ghr_q;

  // Saturating 2-bit counter update from the value read in the previous cycle
  always_comb begin
    upd_cnt = tbl_rdata;
    if (head_taken) begin
      upd_cnt = (tbl_rdata == 2'd3) ? 2'd3 : tbl_rdata + 2'd1;
    end else begin
      upd_cnt = (tbl_rdata == 2'd0) ? 2'd0 : tbl_rdata - 2'd1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a granted read is always followed by its write
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (upd_grant) state_d = StUpdWr;
      StUpdWr: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Table port drive; all zero when the port is unused
  always_comb begin
    tbl_en    = 1'b0;
    tbl_we    = 1'b0;
    tbl_addr  = '0;
    tbl_wdata = 2'd0;
    unique case (state_q)
      StUpdWr: begin
        tbl_en    = 1'b1;
        tbl_we    = 1'b1;
        tbl_addr  = head_idx;
        tbl_wdata = upd_cnt;
      end
      default: begin
        if (upd_grant) begin
          tbl_en   = 1'b1;
          tbl_addr = head_idx;
        end else if (lookup) begin
          tbl_en   = 1'b1;
          tbl_addr = lookup_idx;
        end
      end
    endcase
  end

  // Queue pointers, occupancy, GHR and starvation counter next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ghr_d    = ghr_q;
    starve_d = starve_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      ghr_d    = {ghr_q[GHR_W-2:0], ex_taken};
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
    // Only waiting in IDLE counts; the RMW write cycle holds the count
    if (upd_grant) begin
      starve_d = '0;
    end else if ((state_q == StIdle) && !empty && (starve_q != StarveMax)) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // Control state registers; reset abandons any pending RMW and drops the queue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ghr_q        <= '0;
      starve_q     <= '0;
      pred_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ghr_q        <= ghr_d;
      starve_q     <= starve_d;
      pred_valid_q <= lookup;
    end
  end

  // Queue storage; contents are only meaningful below count_q
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx_q[wr_ptr_q] <= {ghr_q, ex_pc[IDX_W+1:2]};
      fifo_tkn_q[wr_ptr_q] <= ex_taken;
    end
  end

endmodule
